// File: rtl/dft8_frame_loader.sv
// Groups a serial complex-sample stream into 8-sample frames for DFT_8, ping-pong double buffered.
// Latency 1 cycle from slot-7 accept to out_valid; input stalls (in_ready=0) only when both banks hold frames.
module dft8_frame_loader #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sof,
  input  logic [N-1:0]   in_r,
  input  logic [N-1:0]   in_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*N-1:0] frame_r,
  output logic [8*N-1:0] frame_i,
  output logic           sof_err
);

  logic [N-1:0] bank_r [2][8];
  logic [N-1:0] bank_i [2][8];
  logic [2:0]   wr_idx;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   full;
  logic         sof_err_q;

  logic         accept;
  logic         take;
  logic [2:0]   slot;

  assign in_ready  = !rst && !full[wr_ptr];
  assign out_valid = full[rd_ptr];
  assign sof_err   = sof_err_q;
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  // A mid-frame sof restarts the frame at slot 0, abandoning the partial contents.
  assign slot      = in_sof ? 3'd0 : wr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx    <= 3'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      full      <= 2'b00;
      sof_err_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          bank_r[b][k] <= '0;
          bank_i[b][k] <= '0;
        end
      end
    end else begin
      sof_err_q <= accept && in_sof && (wr_idx != 3'd0);
      if (accept) begin
        bank_r[wr_ptr][slot] <= in_r;
        bank_i[wr_ptr][slot] <= in_i;
        wr_idx               <= slot + 3'd1;
        if (slot == 3'd7) begin
          full[wr_ptr] <= 1'b1;
          wr_ptr       <= ~wr_ptr;
        end
      end
      // The write bank is never full while accepting, so it cannot be the bank being released.
      if (take) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
    end
  end

  always_comb begin
    frame_r = '0;
    frame_i = '0;
    for (int k = 0; k < 8; k++) begin
      frame_r[k*N +: N] = bank_r[rd_ptr][k];
      frame_i[k*N +: N] = bank_i[rd_ptr][k];
    end
  end

endmodule

// File: tb/tb_dft8_frame_loader.sv
// Directed and random stimulus for dft8_frame_loader, checked against a queue-based frame model.
module tb_dft8_frame_loader;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_sof = 1'b0;
  logic [N-1:0]   in_r = '0;
  logic [N-1:0]   in_i = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [8*N-1:0] frame_r;
  logic [8*N-1:0] frame_i;
  logic           sof_err;

  dft8_frame_loader #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_ready(out_ready),
    .frame_r(frame_r), .frame_i(frame_i), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8*N-1:0] r;
    logic [8*N-1:0] i;
  } frame_t;

  frame_t       pending[$];
  logic [N-1:0] part_r[$];
  logic [N-1:0] part_i[$];
  bit           exp_sof_err = 1'b0;
  int           checks = 0;
  int           failures = 0;
  int           valid_seen = 0;

  function automatic logic [N-1:0] neg(input logic [N-1:0] v);
    return -v;
  endfunction

  task automatic chk(input string tag, input logic [8*N-1:0] obs, input logic [8*N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model by the handshake outcome.
  task automatic step(input bit v, input bit s, input logic [N-1:0] r, input logic [N-1:0] i,
                      input bit ordy, output bit acc);
    bit     rel;
    frame_t f;
    @(negedge clk);
    in_valid = v; in_sof = s; in_r = r; in_i = i; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, pending.size() < 2);
    chk("out_valid", out_valid, pending.size() > 0);
    chk("sof_err", sof_err, exp_sof_err);
    if (pending.size() > 0) begin
      chk("frame_r", frame_r, pending[0].r);
      chk("frame_i", frame_i, pending[0].i);
    end
    if (out_valid === 1'b1) valid_seen++;
    acc = v && (pending.size() < 2);
    rel = ordy && (pending.size() > 0);
    exp_sof_err = 1'b0;
    if (rel) f = pending.pop_front();
    if (acc) begin
      if (s && part_r.size() != 0) begin
        part_r.delete();
        part_i.delete();
        exp_sof_err = 1'b1;
      end
      part_r.push_back(r);
      part_i.push_back(i);
      if (part_r.size() == 8) begin
        for (int k = 0; k < 8; k++) begin
          f.r[k*N +: N] = part_r[k];
          f.i[k*N +: N] = part_i[k];
        end
        pending.push_back(f);
        part_r.delete();
        part_i.delete();
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_r = $urandom; in_i = $urandom; out_ready = 1'b1;
      #1;
      chk("in_ready_in_rst", in_ready, 0);
      @(posedge clk);
    end
    pending.delete();
    part_r.delete();
    part_i.delete();
    exp_sof_err = 1'b0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_r", frame_r, 0);
    chk("rst_frame_i", frame_i, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    bit           acc;
    logic [N-1:0] v;
    logic [N-1:0] rv;

    do_reset(2);

    // Single frame with sof, consumer always ready.
    for (int k = 0; k < 8; k++) step(1, k == 0, k + 1, neg(k + 1), 1, acc);
    #1;
    chk("t1_valid", out_valid, 1);
    chk("t1_slot0", frame_r[0 +: N], 1);
    chk("t1_slot7", frame_r[7*N +: N], 8);
    chk("t1_im3", frame_i[3*N +: N], neg(4));
    step(0, 0, 0, 0, 1, acc);
    #1;
    chk("t1_one_cycle", out_valid, 0);
    step(0, 0, 0, 0, 1, acc);

    // Consumer stalled: two frames fill, input stalls, one release reopens the input.
    v = 1;
    for (int c = 0; c < 20; c++) begin
      step(1, v == 1, v, neg(v), 0, acc);
      if (acc) v++;
    end
    chk("t2_accepted", v, 17);
    chk("t2_stalled", in_ready, 0);
    chk("t2_held", frame_r[0 +: N], 1);
    step(0, 0, 0, 0, 1, acc);
    #1;
    chk("t2_next_frame", frame_r[0 +: N], 9);
    chk("t2_ready_back", in_ready, 1);
    for (int c = 0; c < 12; c++) begin
      step(v <= 24, 0, v, neg(v), 0, acc);
      if (acc) v++;
    end
    for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 1, acc);

    // Mid-frame sof discards the partial frame.
    for (int k = 1; k <= 3; k++) step(1, k == 1, k, neg(k), 1, acc);
    step(1, 1, 100, neg(100), 1, acc);
    #1;
    chk("t3_sof_err", sof_err, 1);
    for (int k = 101; k <= 107; k++) step(1, 0, k, neg(k), 1, acc);
    #1;
    chk("t3_slot0", frame_r[0 +: N], 100);
    chk("t3_slot1", frame_r[1*N +: N], 101);
    step(0, 0, 0, 0, 1, acc);

    // Sustained throughput.
    step(0, 0, 0, 0, 1, acc);
    valid_seen = 0;
    for (int c = 0; c < 64; c++) step(1, (c % 8) == 0, $urandom, $urandom, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    chk("t4_frames", valid_seen, 8);

    // Reset with one frame pending and a partial one in progress.
    for (int c = 0; c < 13; c++) step(1, 0, $urandom, $urandom, 0, acc);
    do_reset(1);
    for (int k = 0; k < 8; k++) step(1, 0, 200 + k, neg(200 + k), 0, acc);
    #1;
    chk("t5_slot0", frame_r[0 +: N], 200);
    chk("t5_slot7", frame_r[7*N +: N], 207);
    step(0, 0, 0, 0, 1, acc);

    // Push against a full loader with changing data.
    for (int c = 0; c < 16; c++) step(1, c == 0, 300 + c, neg(300 + c), 0, acc);
    for (int c = 0; c < 10; c++) step(1, $urandom_range(0, 1), $urandom, $urandom, 0, acc);
    valid_seen = 0;
    for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 1, acc);
    chk("t6_frames", valid_seen, 2);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rv = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rv, $urandom,
           $urandom_range(0, 2) != 0, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
